multicycle_ctrl: RTL and testbench

- Multicycle control FSM for the 8-bit CPU datapath (16-bit instructions, 4 GPRs, byte-addressed PC advancing by 2).
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB over one shared memory port with a req/ready handshake.
- Drives the datapath strobes: memtoreg, pcsrc, alusrc, regdst, regwrite, jump, alucontrol, plus pc_we, ir_we, iord.
- Counts retired instructions and halts on HALT opcode or illegal opcode.

---
 rtl/multicycle_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the 8-bit CPU datapath.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB over a single
// shared memory port, drives the datapath strobes, counts retired
// instructions and parks in HALT on a HALT or illegal opcode.
module multicycle_ctrl #(
    parameter int CWIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        opcode,
    input  logic [3:0]        funct,
    input  logic              zero,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic              iord,
    output logic              ir_we,
    output logic              pc_we,
    output logic              memtoreg,
    output logic              pcsrc,
    output logic              alusrc,
    output logic              regdst,
    output logic              regwrite,
    output logic              jump,
    output logic [3:0]        alucontrol,
    output logic              halted,
    output logic              illegal,
    output logic [CWIDTH-1:0] instret
);

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0001;
    localparam logic [3:0] OP_LW    = 4'b0010;
    localparam logic [3:0] OP_SW    = 4'b0011;
    localparam logic [3:0] OP_BEQ   = 4'b0100;
    localparam logic [3:0] OP_J     = 4'b0101;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [3:0]        op_q;
    logic [3:0]        funct_q;
    logic              illegal_q;
    logic [CWIDTH-1:0] instret_q;
    logic              retire;
    logic              set_illegal;

    logic              mem_req_c;
    logic              mem_we_c;
    logic              iord_c;
    logic              ir_we_c;
    logic              pc_we_c;
    logic              memtoreg_c;
    logic              pcsrc_c;
    logic              alusrc_c;
    logic              regdst_c;
    logic              regwrite_c;
    logic              jump_c;
    logic [3:0]        alucontrol_c;

    // State register; reset always restarts at FETCH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Capture the opcode/funct while the freshly loaded IR is decoded, so
    // later states do not depend on the IR staying untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q    <= 4'b0000;
            funct_q <= 4'b0000;
        end else if (state == S_DECODE) begin
            op_q    <= opcode;
            funct_q <= funct;
        end
    end

    // Retired-instruction counter (wraps naturally) and sticky illegal flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instret_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            if (retire) begin
                instret_q <= instret_q + CWIDTH'(1);
            end
            if (set_illegal) begin
                illegal_q <= 1'b1;
            end
        end
    end

    // Next-state and strobe decode from the current state and latched opcode.
    always_comb begin
        state_next   = state;
        retire       = 1'b0;
        set_illegal  = 1'b0;
        mem_req_c    = 1'b0;
        mem_we_c     = 1'b0;
        iord_c       = 1'b0;
        ir_we_c      = 1'b0;
        pc_we_c      = 1'b0;
        memtoreg_c   = 1'b0;
        pcsrc_c      = 1'b0;
        alusrc_c     = 1'b0;
        regdst_c     = 1'b0;
        regwrite_c   = 1'b0;
        jump_c       = 1'b0;
        alucontrol_c = 4'b0000;

        case (state)
            S_FETCH: begin
                mem_req_c = 1'b1;
                if (mem_ready) begin
                    ir_we_c    = 1'b1;
                    pc_we_c    = 1'b1;
                    state_next = S_DECODE;
                end
            end

            S_DECODE: begin
                case (opcode)
                    OP_J: begin
                        pc_we_c    = 1'b1;
                        jump_c     = 1'b1;
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end
                    OP_HALT: begin
                        state_next = S_HALT;
                    end
                    OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ: begin
                        state_next = S_EXEC;
                    end
                    default: begin
                        set_illegal = 1'b1;
                        state_next  = S_HALT;
                    end
                endcase
            end

            S_EXEC: begin
                case (op_q)
                    OP_RTYPE: begin
                        alucontrol_c = funct_q;
                        alusrc_c     = 1'b1;
                        state_next   = S_WB;
                    end
                    OP_ADDI: begin
                        alucontrol_c = ALU_ADD;
                        state_next   = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        alucontrol_c = ALU_ADD;
                        state_next   = S_MEM;
                    end
                    OP_BEQ: begin
                        alucontrol_c = ALU_SUB;
                        alusrc_c     = 1'b1;
                        pcsrc_c      = 1'b1;
                        pc_we_c      = zero;
                        retire       = 1'b1;
                        state_next   = S_FETCH;
                    end
                    default: begin
                        state_next = S_HALT;
                    end
                endcase
            end

            S_MEM: begin
                mem_req_c = 1'b1;
                iord_c    = 1'b1;
                mem_we_c  = (op_q == OP_SW);
                if (mem_ready) begin
                    if (op_q == OP_LW) begin
                        state_next = S_WB;
                    end else begin
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end
                end
            end

            S_WB: begin
                regwrite_c = 1'b1;
                memtoreg_c = (op_q != OP_LW);
                regdst_c   = (op_q == OP_RTYPE);
                retire     = 1'b1;
                state_next = S_FETCH;
            end

            S_HALT: begin
                state_next = S_HALT;
            end

            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    // Every strobe is gated by reset so an asserted reset silences the
    // datapath and the memory port immediately, without a clock edge.
    assign mem_req    = reset & mem_req_c;
    assign mem_we     = reset & mem_we_c;
    assign iord       = reset & iord_c;
    assign ir_we      = reset & ir_we_c;
    assign pc_we      = reset & pc_we_c;
    assign memtoreg   = reset & memtoreg_c;
    assign pcsrc      = reset & pcsrc_c;
    assign alusrc     = reset & alusrc_c;
    assign regdst     = reset & regdst_c;
    assign regwrite   = reset & regwrite_c;
    assign jump       = reset & jump_c;
    assign alucontrol = reset ? alucontrol_c : 4'b0000;
    assign halted     = reset & (state == S_HALT);
    assign illegal    = illegal_q;
    assign instret    = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: a small IR model feeds opcodes,
// and per-instruction latency, strobe counts and retire counts are checked
// against expectations derived from the instruction-level behaviour.
module tb_multicycle_ctrl;

    localparam int CWIDTH = 8;

    localparam logic [3:0] OP_R    = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b0001;
    localparam logic [3:0] OP_LW   = 4'b0010;
    localparam logic [3:0] OP_SW   = 4'b0011;
    localparam logic [3:0] OP_BEQ  = 4'b0100;
    localparam logic [3:0] OP_J    = 4'b0101;
    localparam logic [3:0] OP_HALT = 4'b1111;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [3:0]        opcode = 4'b0000;
    logic [3:0]        funct = 4'b0000;
    logic              zero = 1'b0;
    logic              mem_ready = 1'b0;
    logic              mem_req, mem_we, iord, ir_we, pc_we;
    logic              memtoreg, pcsrc, alusrc, regdst, regwrite, jump;
    logic [3:0]        alucontrol;
    logic              halted, illegal;
    logic [CWIDTH-1:0] instret;

    int total_checks = 0;
    int bad_checks   = 0;
    int exp_instret  = 0;

    multicycle_ctrl #(.CWIDTH(CWIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .memtoreg   (memtoreg),
        .pcsrc      (pcsrc),
        .alusrc     (alusrc),
        .regdst     (regdst),
        .regwrite   (regwrite),
        .jump       (jump),
        .alucontrol (alucontrol),
        .halted     (halted),
        .illegal    (illegal),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    function automatic bit is_legal(input logic [3:0] op);
        return (op <= OP_J) || (op == OP_HALT);
    endfunction

    // Cycle count of one instruction: fixed cost per class plus wait cycles.
    function automatic int exp_cycles(input logic [3:0] op, input int fw, input int mw);
        case (op)
            OP_R, OP_ADDI: return 4 + fw;
            OP_LW:         return 5 + fw + mw;
            OP_SW:         return 4 + fw + mw;
            OP_BEQ:        return 3 + fw;
            OP_J:          return 2 + fw;
            default:       return 2 + fw;
        endcase
    endfunction

    // Reset pulse; released just after a rising edge so the next cycle is the first FETCH.
    task automatic do_reset();
        mem_ready = 1'b0;
        #2 reset = 1'b0;
        opcode = 4'b0000;
        funct  = 4'b0000;
        zero   = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        exp_instret = 0;
    endtask

    // Runs one instruction with fw fetch waits and mw memory waits and checks it.
    task automatic run_instr(input logic [3:0] op, input logic [3:0] fn, input logic z,
                             input int fw, input int mw);
        int  n_cyc, fcnt, mcnt, n_rw, rw_idx, n_memwe, n_pcwe, n_jpc, n_bpc, n_irwe;
        bit  memwe_bad, load_ir, term, has_exec, is_mem;
        logic rw_dst, rw_m2r, ex_src;
        logic [3:0] ex_alu, want_alu;
        logic [1:0] first_port;
        n_cyc = exp_cycles(op, fw, mw);
        fcnt = 0; mcnt = 0; n_rw = 0; rw_idx = -1; n_memwe = 0; n_pcwe = 0;
        n_jpc = 0; n_bpc = 0; n_irwe = 0; memwe_bad = 0;
        rw_dst = 1'b0; rw_m2r = 1'b0; ex_src = 1'b0; ex_alu = 4'b0000;
        first_port = 2'b00;
        term     = (op == OP_HALT) || !is_legal(op);
        has_exec = !term && (op != OP_J);
        is_mem   = (op == OP_LW) || (op == OP_SW);
        zero = z;
        for (int idx = 0; idx < n_cyc; idx++) begin
            @(negedge clk);
            if (mem_req && !iord)     mem_ready = (fcnt >= fw);
            else if (mem_req && iord) mem_ready = (mcnt >= mw);
            else                      mem_ready = 1'($urandom_range(0, 1));
            #1;
            if (idx == 0) first_port = {mem_req, iord};
            if (mem_req && !iord) fcnt++;
            if (mem_req && iord)  mcnt++;
            if (regwrite) begin n_rw++; rw_idx = idx; rw_dst = regdst; rw_m2r = memtoreg; end
            if (mem_we) begin n_memwe++; if (!(mem_req && iord)) memwe_bad = 1; end
            if (pc_we) n_pcwe++;
            if (pc_we && jump) n_jpc++;
            if (pc_we && pcsrc) n_bpc++;
            if (ir_we) n_irwe++;
            if (idx == fw + 2) begin ex_alu = alucontrol; ex_src = alusrc; end
            load_ir = ir_we;
            @(posedge clk);
            #1;
            if (load_ir) begin opcode = op; funct = fn; end
        end
        if (!term) exp_instret++;

        total_checks++;
        if (first_port !== 2'b10) begin bad_checks++;
            $display("[TB] FAIL fetch_start op=%b got {req,iord}=%b want 10", op, first_port); end
        total_checks++;
        if (fcnt !== fw + 1) begin bad_checks++;
            $display("[TB] FAIL fetch_req_cycles op=%b got %0d want %0d", op, fcnt, fw + 1); end
        total_checks++;
        if (mcnt !== (is_mem ? mw + 1 : 0)) begin bad_checks++;
            $display("[TB] FAIL mem_req_cycles op=%b got %0d want %0d", op, mcnt, is_mem ? mw + 1 : 0); end
        total_checks++;
        if (n_irwe !== 1) begin bad_checks++;
            $display("[TB] FAIL ir_we_count op=%b got %0d want 1", op, n_irwe); end
        total_checks++;
        if (n_memwe !== ((op == OP_SW) ? mw + 1 : 0) || memwe_bad) begin bad_checks++;
            $display("[TB] FAIL mem_we op=%b got %0d (outside mem=%0d) want %0d", op, n_memwe, memwe_bad, (op == OP_SW) ? mw + 1 : 0); end
        total_checks++;
        if (n_pcwe !== 1 + ((op == OP_J) ? 1 : 0) + ((op == OP_BEQ && z) ? 1 : 0)) begin bad_checks++;
            $display("[TB] FAIL pc_we_count op=%b z=%b got %0d", op, z, n_pcwe); end
        total_checks++;
        if (n_jpc !== ((op == OP_J) ? 1 : 0) || n_bpc !== ((op == OP_BEQ && z) ? 1 : 0)) begin bad_checks++;
            $display("[TB] FAIL pc_source op=%b z=%b got jump=%0d branch=%0d", op, z, n_jpc, n_bpc); end
        if (op == OP_R || op == OP_ADDI || op == OP_LW) begin
            total_checks++;
            if (n_rw !== 1 || rw_idx !== n_cyc - 1) begin bad_checks++;
                $display("[TB] FAIL regwrite op=%b got count=%0d at=%0d want 1 at %0d", op, n_rw, rw_idx, n_cyc - 1); end
            total_checks++;
            if (rw_dst !== (op == OP_R) || rw_m2r !== (op != OP_LW)) begin bad_checks++;
                $display("[TB] FAIL wb_muxes op=%b got regdst=%b memtoreg=%b", op, rw_dst, rw_m2r); end
        end else begin
            total_checks++;
            if (n_rw !== 0) begin bad_checks++;
                $display("[TB] FAIL no_regwrite op=%b got %0d want 0", op, n_rw); end
        end
        if (has_exec) begin
            want_alu = (op == OP_R) ? fn : (op == OP_BEQ) ? 4'b0110 : 4'b0010;
            total_checks++;
            if (ex_alu !== want_alu || ex_src !== (op == OP_R || op == OP_BEQ)) begin bad_checks++;
                $display("[TB] FAIL exec_alu op=%b got alu=%b src=%b want alu=%b", op, ex_alu, ex_src, want_alu); end
        end
        total_checks++;
        if (halted !== term || illegal !== !is_legal(op)) begin bad_checks++;
            $display("[TB] FAIL halt_flags op=%b got halted=%b illegal=%b", op, halted, illegal); end
        total_checks++;
        if (instret !== CWIDTH'(exp_instret)) begin bad_checks++;
            $display("[TB] FAIL instret op=%b got %0d want %0d", op, instret, exp_instret % 256); end
    endtask

    // Reset forces every output low and the first cycle afterwards fetches.
    task automatic test_reset();
        $display("[TB] test_reset");
        do_reset();
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        total_checks++;
        if ({mem_req, mem_we, iord, ir_we, pc_we, regwrite, jump, alucontrol, halted, illegal} !== 15'd0
            || instret !== '0) begin bad_checks++;
            $display("[TB] FAIL reset_outputs got req=%b pc_we=%b instret=%0d want all 0", mem_req, pc_we, instret); end
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        #1;
        total_checks++;
        if ({mem_req, iord, ir_we} !== 3'b100) begin bad_checks++;
            $display("[TB] FAIL first_fetch got req/iord/ir_we=%b want 100", {mem_req, iord, ir_we}); end
        exp_instret = 0;
        do_reset();
    endtask

    // ADDI, R-type, HALT with memory always ready.
    task automatic test_alu_seq();
        $display("[TB] test_alu_seq");
        do_reset();
        run_instr(OP_ADDI, 4'b0000, 1'b0, 0, 0);
        run_instr(OP_R,    4'b0010, 1'b0, 0, 0);
        run_instr(OP_HALT, 4'b0000, 1'b0, 0, 0);
        total_checks++;
        if (instret !== CWIDTH'(2)) begin bad_checks++;
            $display("[TB] FAIL alu_seq_instret got %0d want 2", instret); end
    endtask

    // LW with three wait cycles in fetch and in memory.
    task automatic test_lw_waits();
        $display("[TB] test_lw_waits");
        do_reset();
        run_instr(OP_LW, 4'b0000, 1'b0, 3, 3);
    endtask

    // Taken and not-taken branch.
    task automatic test_beq();
        $display("[TB] test_beq");
        do_reset();
        run_instr(OP_BEQ, 4'b0000, 1'b1, 0, 0);
        run_instr(OP_BEQ, 4'b0000, 1'b0, 0, 0);
    endtask

    // Store followed by jump.
    task automatic test_sw_j();
        $display("[TB] test_sw_j");
        do_reset();
        run_instr(OP_SW, 4'b0000, 1'b0, 0, 1);
        run_instr(OP_J,  4'b0000, 1'b0, 1, 0);
    endtask

    // Illegal opcode parks the controller until reset.
    task automatic test_illegal(input logic [3:0] op);
        int active;
        $display("[TB] test_illegal op=%b", op);
        do_reset();
        run_instr(OP_ADDI, 4'b0000, 1'b0, 0, 0);
        run_instr(op, 4'b0000, 1'b0, 0, 0);
        active = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            mem_ready = 1'($urandom_range(0, 1));
            opcode = 4'($urandom);
            #1;
            if (mem_req || ir_we || pc_we || regwrite || mem_we || jump || alucontrol != 4'b0000 || !halted)
                active++;
        end
        total_checks++;
        if (active !== 0 || instret !== CWIDTH'(1)) begin bad_checks++;
            $display("[TB] FAIL halt_hold got active_cycles=%0d instret=%0d want 0 and 1", active, instret); end
        do_reset();
        #1;
        total_checks++;
        if (halted !== 1'b0 || illegal !== 1'b0) begin bad_checks++;
            $display("[TB] FAIL halt_cleared got halted=%b illegal=%b want 0 0", halted, illegal); end
    endtask

    // Reset in the middle of a stalled LW memory access.
    task automatic test_async_reset();
        $display("[TB] test_async_reset");
        do_reset();
        run_instr(OP_ADDI, 4'b0000, 1'b0, 0, 0);
        @(negedge clk); mem_ready = 1'b1;
        @(posedge clk); #1 opcode = OP_LW;
        repeat (2) begin @(negedge clk); mem_ready = 1'b0; @(posedge clk); end
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        total_checks++;
        if ({mem_req, iord} !== 2'b11) begin bad_checks++;
            $display("[TB] FAIL mem_stall got req/iord=%b want 11", {mem_req, iord}); end
        #2 reset = 1'b0;
        #1;
        total_checks++;
        if (mem_req !== 1'b0 || instret !== '0) begin bad_checks++;
            $display("[TB] FAIL async_drop got mem_req=%b instret=%0d want 0 0", mem_req, instret); end
        @(posedge clk);
        #1 reset = 1'b1;
        exp_instret = 0;
        run_instr(OP_ADDI, 4'b0000, 1'b0, 0, 0);
    endtask

    // 256 ADDIs wrap the 8-bit counter back to zero.
    task automatic test_wrap();
        $display("[TB] test_wrap");
        do_reset();
        for (int i = 0; i < 256; i++) run_instr(OP_ADDI, 4'b0000, 1'b0, 0, 0);
        total_checks++;
        if (instret !== '0) begin bad_checks++;
            $display("[TB] FAIL wrap got %0d want 0", instret); end
    endtask

    // Random mix of legal non-halting instructions with random waits.
    task automatic test_random();
        logic [3:0] ops [6];
        $display("[TB] test_random");
        ops = '{OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J};
        do_reset();
        for (int i = 0; i < 60; i++) begin
            run_instr(ops[$urandom_range(0, 5)], 4'($urandom), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 2), $urandom_range(0, 2));
        end
    endtask

    initial begin
        test_reset();
        test_alu_seq();
        test_lw_waits();
        test_beq();
        test_sw_j();
        test_illegal(4'b0111);
        test_illegal(4'($urandom_range(6, 14)));
        test_async_reset();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
